program_loader: RTL

Writable instruction store for the ALU test datapath. Accepts a byte stream over a valid/ready handshake, packs every three bytes into one 19-bit instruction word `{sel[2:0], inmA[7:0], inmB[7:0]}`, and writes it into a 64-entry RAM. The program sequencer reads the RAM through a registered read port. The block is the writer end of the instruction-word format that the address counter and splitter consume.

---
 rtl/program_loader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: packs a byte stream into {sel, inmA, inmB} instruction words and stores them in RAM.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the last word.
module program_loader #(
  parameter int DEPTH  = 64,
  parameter int WORD_W = 19
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  input  logic                       in_last,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [WORD_W-1:0]          rd_data,
  output logic                       loaded,
  output logic                       error,
  output logic [$clog2(DEPTH):0]     word_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] B0   = 3'd1;
  localparam logic [2:0] B1   = 3'd2;
  localparam logic [2:0] B2   = 3'd3;
  localparam logic [2:0] DONE = 3'd5;
  localparam logic [2:0] ERR  = 3'd6;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] CSUM = 3'd4;
`endif

  logic [2:0]        state_reg, state_next;
  logic [2:0]        sel_reg, sel_next;
  logic [7:0]        inma_reg, inma_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [CW-1:0]     count_inc;
  logic              accept;
  logic              wr_en;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] mem [DEPTH];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_reg, csum_next;
`endif

  always_comb begin
    in_ready = (state_reg == B0) || (state_reg == B1) || (state_reg == B2);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (state_reg == CSUM) in_ready = 1'b1;
`endif
  end

  assign accept     = in_valid & in_ready;
  assign count_inc  = count_reg + 1'b1;
  assign wr_word    = {sel_reg, inma_reg, in_data};
  assign loaded     = (state_reg == DONE);
  assign error      = (state_reg == ERR);
  assign word_count = count_reg;

  // start wins over a byte accepted in the same cycle; that byte is dropped
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    inma_next  = inma_reg;
    count_next = count_reg;
    wr_en      = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_next  = csum_reg;
`endif
    if (start) begin
      state_next = B0;
      count_next = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_next  = '0;
`endif
    end else if (accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_next = csum_reg ^ in_data;
`endif
      case (state_reg)
        B0: begin
          if ((in_data[7:3] != 5'd0) || in_last) begin
            state_next = ERR;
          end else begin
            sel_next   = in_data[2:0];
            state_next = B1;
          end
        end
        B1: begin
          if (in_last) begin
            state_next = ERR;
          end else begin
            inma_next  = in_data;
            state_next = B2;
          end
        end
        B2: begin
          wr_en      = 1'b1;
          count_next = count_inc;
          if (in_last) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          end else if (count_inc == CW'(DEPTH)) begin
            state_next = ERR;
          end else begin
            state_next = B0;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CSUM: state_next = (in_data == csum_reg) ? DONE : ERR;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      inma_reg  <= '0;
      count_reg <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      inma_reg  <= inma_next;
      count_reg <= count_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[count_reg[AW-1:0]] <= wr_word;
  end

  // Registered, read-first port; addresses beyond the current load read as a no-op word
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if ({1'b0, rd_addr} < count_reg) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule
